// File: rtl/fpu_share_pkg.sv
// fpu_share_pkg: shared types and round-robin helper for the FPU sharing arbiter
package fpu_share_pkg;

    localparam int DEF_NB_REQ          = 4;
    localparam int DEF_TAG_WIDTH       = 4;
    localparam int DEF_NB_ARGS         = 3;
    localparam int DEF_DATA_WIDTH      = 32;
    localparam int DEF_OPCODE_WIDTH    = 6;
    localparam int DEF_FLAGS_IN_WIDTH  = 15;
    localparam int DEF_FLAGS_OUT_WIDTH = 5;
    localparam int DEF_MAX_OUTSTANDING = 4;
    localparam int DEF_IDX_WIDTH       = $clog2(DEF_NB_REQ);
    localparam int RR_MAX              = 64;

    typedef struct packed {
        logic [DEF_NB_ARGS-1:0][DEF_DATA_WIDTH-1:0] operands;
        logic [DEF_OPCODE_WIDTH-1:0]                op;
        logic [DEF_FLAGS_IN_WIDTH-1:0]              flags;
        logic [DEF_TAG_WIDTH-1:0]                   tag;
    } req_payload_t;

    typedef struct packed {
        logic [DEF_TAG_WIDTH-1:0] tag;
        logic [DEF_IDX_WIDTH-1:0] idx;
    } fpu_id_t;

    // First set bit of elig at or above ptr, wrapping at n; 0 when none is set.
    function automatic int rr_pick(input logic [RR_MAX-1:0] elig, input int ptr, input int n);
        int pick;
        pick = 0;
        for (int i = RR_MAX - 1; i >= 0; i--)
            if (i < n && elig[(ptr + i) % n]) pick = (ptr + i) % n;
        return pick;
    endfunction

endpackage

// File: rtl/fpu_share_rr_arb.sv
// fpu_share_rr_arb: round-robin pointer and one-hot winner selection
module fpu_share_rr_arb import fpu_share_pkg::*; #(
    parameter  int NB_REQ    = DEF_NB_REQ,
    localparam int IDX_WIDTH = $clog2(NB_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NB_REQ-1:0]    elig_i,
    input  logic                 gnt_i,
    output logic                 valid_o,
    output logic [IDX_WIDTH-1:0] win_o,
    output logic [NB_REQ-1:0]    win_oh_o
);

    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;

    // Pick the winner from the pointer upward; advance past it only on a handshake.
    always_comb begin
        valid_o  = |elig_i;
        win_o    = IDX_WIDTH'(rr_pick(RR_MAX'(elig_i), int'(ptr_q), NB_REQ));
        win_oh_o = valid_o ? (NB_REQ'(1) << win_o) : '0;
        ptr_d    = (valid_o && gnt_i) ? ((int'(win_o) == NB_REQ - 1) ? '0 : win_o + 1'b1) : ptr_q;
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;

endmodule

// File: rtl/fpu_share_arbiter.sv
// fpu_share_arbiter: shares one FPU between requesters with outstanding limits and ID-routed responses
module fpu_share_arbiter import fpu_share_pkg::*; #(
    parameter  int NB_REQ          = DEF_NB_REQ,
    parameter  int TAG_WIDTH       = DEF_TAG_WIDTH,
    parameter  int NB_ARGS         = DEF_NB_ARGS,
    parameter  int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter  int OPCODE_WIDTH    = DEF_OPCODE_WIDTH,
    parameter  int FLAGS_IN_WIDTH  = DEF_FLAGS_IN_WIDTH,
    parameter  int FLAGS_OUT_WIDTH = DEF_FLAGS_OUT_WIDTH,
    parameter  int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    localparam int IDX_WIDTH       = $clog2(NB_REQ)
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [NB_REQ-1:0]                               req_i,
    output logic [NB_REQ-1:0]                               gnt_o,
    input  logic [NB_REQ-1:0][TAG_WIDTH-1:0]                tag_i,
    input  logic [NB_REQ-1:0][NB_ARGS-1:0][DATA_WIDTH-1:0]  operands_i,
    input  logic [NB_REQ-1:0][OPCODE_WIDTH-1:0]             op_i,
    input  logic [NB_REQ-1:0][FLAGS_IN_WIDTH-1:0]           flags_i,
    output logic [NB_REQ-1:0]                               rvalid_o,
    output logic [DATA_WIDTH-1:0]                           rdata_o,
    output logic [FLAGS_OUT_WIDTH-1:0]                      rflags_o,
    output logic [TAG_WIDTH-1:0]                            rtag_o,
    output logic                                            fpu_req_o,
    input  logic                                            fpu_gnt_i,
    output logic [TAG_WIDTH+IDX_WIDTH-1:0]                  fpu_id_o,
    output logic [NB_ARGS-1:0][DATA_WIDTH-1:0]              fpu_operands_o,
    output logic [OPCODE_WIDTH-1:0]                         fpu_op_o,
    output logic [FLAGS_IN_WIDTH-1:0]                       fpu_flags_o,
    input  logic                                            fpu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                           fpu_rdata_i,
    input  logic [FLAGS_OUT_WIDTH-1:0]                      fpu_rflags_i,
    input  logic [TAG_WIDTH+IDX_WIDTH-1:0]                  fpu_rid_i,
    output logic                                            err_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0]              cnt_q [NB_REQ];
    logic [CW-1:0]              cnt_d [NB_REQ];
    logic [NB_REQ-1:0]          elig, win_oh, rvalid_d;
    logic [IDX_WIDTH-1:0]       win, rid_idx;
    logic [TAG_WIDTH-1:0]       rid_tag, rtag_d;
    logic [DATA_WIDTH-1:0]      rdata_d;
    logic [FLAGS_OUT_WIDTH-1:0] rflags_d;
    logic [2**IDX_WIDTH-1:0]    idx_map;
    logic                       hs, idx_ok, rsp_ok, err_d, err_q;

    for (genvar g = 0; g < 2**IDX_WIDTH; g++) begin : g_idx_map
        assign idx_map[g] = (g < NB_REQ);
    end

    for (genvar g = 0; g < NB_REQ; g++) begin : g_elig
        assign elig[g] = req_i[g] && (cnt_q[g] != CW'(MAX_OUTSTANDING));
    end

    fpu_share_rr_arb #(.NB_REQ(NB_REQ)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .elig_i   (elig),
        .gnt_i    (fpu_gnt_i),
        .valid_o  (fpu_req_o),
        .win_o    (win),
        .win_oh_o (win_oh)
    );

    assign hs             = fpu_req_o && fpu_gnt_i;
    assign gnt_o          = win_oh & {NB_REQ{fpu_gnt_i}};
    assign fpu_id_o       = {tag_i[win], win};
    assign fpu_operands_o = operands_i[win];
    assign fpu_op_o       = op_i[win];
    assign fpu_flags_o    = flags_i[win];
    assign rid_idx        = fpu_rid_i[IDX_WIDTH-1:0];
    assign rid_tag        = fpu_rid_i[TAG_WIDTH+IDX_WIDTH-1:IDX_WIDTH];
    assign idx_ok         = idx_map[rid_idx];
    assign rsp_ok         = fpu_rvalid_i && idx_ok;

    // Counter updates, response routing and sticky error detection.
    always_comb begin
        err_d    = err_q | (fpu_rvalid_i & ~idx_ok);
        rvalid_d = '0;
        rdata_d  = rsp_ok ? fpu_rdata_i  : rdata_o;
        rflags_d = rsp_ok ? fpu_rflags_i : rflags_o;
        rtag_d   = rsp_ok ? rid_tag      : rtag_o;
        for (int i = 0; i < NB_REQ; i++) begin
            rvalid_d[i] = rsp_ok && (rid_idx == IDX_WIDTH'(i));
            err_d       = err_d | (rvalid_d[i] && (cnt_q[i] == '0));
            cnt_d[i]    = cnt_q[i] + CW'(hs && (win == IDX_WIDTH'(i)))
                                   - CW'(rvalid_d[i] && (cnt_q[i] != '0));
        end
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < NB_REQ; i++) cnt_q[i] <= '0;
            rvalid_o <= '0;
            rdata_o  <= '0;
            rflags_o <= '0;
            rtag_o   <= '0;
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < NB_REQ; i++) cnt_q[i] <= cnt_d[i];
            rvalid_o <= rvalid_d;
            rdata_o  <= rdata_d;
            rflags_o <= rflags_d;
            rtag_o   <= rtag_d;
            err_q    <= err_d;
        end

    assign err_o = err_q;

endmodule

// File: doc/fpu_share_arbiter.md
Name: fpu_share_arbiter

Overview:
- Shares one FP unit instance (APU-style req/gnt, rvalid port, tagged by ID) between NB_REQ requesters, typically the cores of a cluster.
- Request path: round-robin arbitration with a per-requester outstanding-transaction limit.
- Response path: routed back by the requester index carried in the FPU ID field.
- Sits between the core APU ports and the FPU wrapper; the FPU result port is always-ready.

Parameters:
- NB_REQ, 4, number of requesters (>=2).
- TAG_WIDTH, 4, requester-local tag, passed through unchanged.
- IDX_WIDTH, $clog2(NB_REQ), requester index width (localparam).
- NB_ARGS, 3, operands per operation.
- DATA_WIDTH, 32, operand/result width.
- OPCODE_WIDTH, 6, opcode width.
- FLAGS_IN_WIDTH, 15, request flags width.
- FLAGS_OUT_WIDTH, 5, status flags width.
- MAX_OUTSTANDING, 4, in-flight ops allowed per requester (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_i  in  NB_REQ  per-requester request.
- gnt_o  out  NB_REQ  per-requester grant.
- tag_i  in  NB_REQ x TAG_WIDTH  requester tag.
- operands_i  in  NB_REQ x NB_ARGS x DATA_WIDTH  operands.
- op_i  in  NB_REQ x OPCODE_WIDTH  opcode.
- flags_i  in  NB_REQ x FLAGS_IN_WIDTH  request flags.
- rvalid_o  out  NB_REQ  response valid.
- rdata_o  out  DATA_WIDTH  result, shared by all requesters; qualify with rvalid_o.
- rflags_o  out  FLAGS_OUT_WIDTH  status flags, shared.
- rtag_o  out  TAG_WIDTH  returned tag, shared.
- fpu_req_o  out  1  request to FPU.
- fpu_gnt_i  in  1  FPU ready.
- fpu_id_o  out  TAG_WIDTH+IDX_WIDTH  {tag, index}.
- fpu_operands_o  out  NB_ARGS x DATA_WIDTH  operands to FPU.
- fpu_op_o  out  OPCODE_WIDTH  opcode to FPU.
- fpu_flags_o  out  FLAGS_IN_WIDTH  flags to FPU.
- fpu_rvalid_i  in  1  FPU result valid.
- fpu_rdata_i  in  DATA_WIDTH  FPU result.
- fpu_rflags_i  in  FLAGS_OUT_WIDTH  FPU status flags.
- fpu_rid_i  in  TAG_WIDTH+IDX_WIDTH  returned ID.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset: all of the following are 0 — gnt_o, rvalid_o, rdata_o, rflags_o, rtag_o, err_o, RR pointer, outstanding counters. fpu_req_o is 0 while no eligible request.
- Eligible[i] = req_i[i] && cnt[i] != MAX_OUTSTANDING.
- Arbitration: combinational round-robin over eligible, searching upward from pointer ptr with wrap NB_REQ-1 -> 0.
  - fpu_req_o = |eligible.
  - Winner's payload is muxed to fpu_* outputs; fpu_id_o = {tag_i[w], w}.
- Grant: gnt_o[w] = fpu_gnt_i && fpu_req_o, one-hot, zero-latency. Non-winners get gnt 0.
- Handshake (fpu_req_o && fpu_gnt_i): ptr <= (w+1) mod NB_REQ. With no handshake, ptr holds.
- Requester contract: requester holds req and payload until gnt. The arbiter does not lock the choice, so the winner may change between cycles while the FPU stalls; the FPU sees a valid-stable request only per-cycle.
- Counters, all in the same cycle:
  - cnt[w]++ on handshake.
  - cnt[k]-- on fpu_rvalid_i with fpu_rid_i index k.
  - Increment and decrement on the same k: unchanged.
  - Width is $clog2(MAX_OUTSTANDING+1); never exceeds MAX_OUTSTANDING.
- Response: registered, latency 1 cycle.
  - fpu_rvalid_i with index k -> next cycle rvalid_o one-hot at bit k; rdata_o, rflags_o, rtag_o = captured values.
  - rvalid_o is a single-cycle pulse; no backpressure, so requesters must accept.
- Errors, both set err_o and it stays set until reset:
  - Response index >= NB_REQ: response dropped.
  - Response for a requester with cnt==0: rvalid still forwarded, counter held at 0.
- Reset mid-operation: everything clears asynchronously. The FPU is expected to be reset by the same rst_n, so no stale responses occur.

Decomposition:
- Package fpu_share_pkg:
  - typedef req_payload_t (operands, op, flags, tag).
  - typedef fpu_id_t (packed {tag, idx}).
  - function rr_pick (priority search from pointer).
- Sub-module: fpu_share_rr_arb, holding the RR pointer and one-hot winner logic. Counters and the response register stay in the top.

Test Plan:
- Single requester: req_i=4'b0010, tag 5, fpu_gnt_i=1.
  - -> gnt_o=4'b0010, fpu_id_o={4'd5,2'd1}.
  - FPU returns rid {5,1}, rdata 32'h3F800000 -> next cycle rvalid_o=4'b0010, rdata_o=32'h3F800000, rtag_o=5.
- All four requesting continuously, fpu_gnt_i=1, ptr=0 at reset -> grants cycle 0001, 0010, 0100, 1000, 0001.
- Outstanding cap: req_i[0] held, MAX_OUTSTANDING=4, no responses.
  - -> exactly 4 grants, then gnt_o[0]=0 and fpu_req_o=0.
  - One response for index 0 -> exactly one further grant.
- Simultaneous: handshake and response both for requester 2 when cnt[2]=3 -> cnt[2] stays 3, no error.
- fpu_gnt_i=0 for 3 cycles with req_i=4'b0101 -> no grants, ptr unchanged. Then fpu_gnt_i=1 -> gnt_o=4'b0001.
- Response with index 1 while cnt[1]=0 -> err_o=1 next cycle, rvalid_o[1] pulses, err_o stays 1 until rst_n low.
